// File: rtl/gf_serial_mult_unit.sv
// Bit-serial GF(2^m) multiplier with runtime degree m (1..DATA_WIDTH) and runtime
// reduction polynomial; operands arrive MSB-first and the product drains MSB-first.
module gf_serial_mult_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int WW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WW-1:0]         width,
    input  logic [DATA_WIDTH-1:0] poly,
    input  logic                  in_valid,
    input  logic                  in_a,
    input  logic                  in_b,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_bit,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_DRAIN
    } state_t;

    state_t                state_reg;
    logic [WW-1:0]         m_reg;
    logic [WW-1:0]         cnt_reg;
    logic [DATA_WIDTH-1:0] poly_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] acc_reg;
    logic                  busy_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
    logic                  done_reg;
    logic                  err_reg;

    // m_mask keeps bits below m, m_msb is one-hot at bit m-1, width_mask masks
    // the incoming polynomial against the requested degree before it is latched.
    logic [DATA_WIDTH-1:0] m_mask;
    logic [DATA_WIDTH-1:0] m_msb;
    logic [DATA_WIDTH-1:0] width_mask;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
            assign m_mask[gi]     = (WW'(gi) < m_reg);
            assign m_msb[gi]      = (m_reg == WW'(gi + 1));
            assign width_mask[gi] = (WW'(gi) < width);
        end
    endgenerate

    logic                  width_ok;
    logic                  cnt_last;
    logic                  acc_msb;
    logic                  b_msb;
    logic                  in_xfer;
    logic                  out_xfer;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] a_shift;
    logic [DATA_WIDTH-1:0] b_shift;

    assign width_ok = (width != '0) && (width <= WW'(DATA_WIDTH));
    assign cnt_last = ((cnt_reg + WW'(1)) == m_reg);
    assign acc_msb  = |(acc_reg & m_msb);
    assign b_msb    = |(b_reg & m_msb);
    assign in_xfer  = in_ready_reg & in_valid;
    assign out_xfer = out_valid_reg & out_ready;

    // Horner step: multiply the running sum by x, reduce, then add A if B's current bit is set.
    assign acc_next = (((acc_reg << 1) ^ (acc_msb ? poly_reg : '0)) & m_mask)
                      ^ (b_msb ? a_reg : '0);
    assign a_shift  = ((a_reg << 1) | DATA_WIDTH'(in_a)) & m_mask;
    assign b_shift  = ((b_reg << 1) | DATA_WIDTH'(in_b)) & m_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            m_reg         <= '0;
            cnt_reg       <= '0;
            poly_reg      <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (width_ok) begin
                            m_reg        <= width;
                            poly_reg     <= poly & width_mask;
                            a_reg        <= '0;
                            b_reg        <= '0;
                            acc_reg      <= '0;
                            cnt_reg      <= '0;
                            busy_reg     <= 1'b1;
                            in_ready_reg <= 1'b1;
                            state_reg    <= ST_LOAD;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_xfer) begin
                        a_reg <= a_shift;
                        b_reg <= b_shift;
                        if (cnt_last) begin
                            cnt_reg      <= '0;
                            in_ready_reg <= 1'b0;
                            state_reg    <= ST_MULT;
                        end else begin
                            cnt_reg <= cnt_reg + WW'(1);
                        end
                    end
                end
                ST_MULT: begin
                    // B is consumed MSB-first by shifting it up past bit m-1.
                    acc_reg <= acc_next;
                    b_reg   <= (b_reg << 1) & m_mask;
                    if (cnt_last) begin
                        cnt_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + WW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        acc_reg <= (acc_reg << 1) & m_mask;
                        if (cnt_last) begin
                            cnt_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + WW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_bit   = out_valid_reg & acc_msb;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_gf_serial_mult_unit.sv
// Directed bench for gf_serial_mult_unit: serial load/drain with stalls, illegal widths,
// mid-operation reset and back-to-back starts, all against hand-computed products.
module tb_gf_serial_mult_unit;

    localparam int DATA_WIDTH = 8;
    localparam int WW         = $clog2(DATA_WIDTH + 1);

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [WW-1:0]         width;
    logic [DATA_WIDTH-1:0] poly;
    logic                  in_valid;
    logic                  in_a;
    logic                  in_b;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_bit;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  err;

    int checks = 0;
    int errors = 0;

    gf_serial_mult_unit #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .width     (width),
        .poly      (poly),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation starting at the current falling edge; returns the drained result
    // and the number of cycles from the start edge to the cycle where done is seen.
    task automatic do_op(input int m, input logic [7:0] p, input logic [7:0] a, input logic [7:0] b,
                         input bit in_alt, input int ostall_at, input int ostall_len, input bit spam,
                         output logic [7:0] res, output int lat);
        int n;
        int k;
        int j;
        int srem;
        bit tog;
        bit stalled_once;
        bit held_bit;
        bit got_done;
        res          = '0;
        lat          = -1;
        n            = 0;
        k            = 0;
        j            = 0;
        srem         = 0;
        tog          = 1'b0;
        stalled_once = 1'b0;
        held_bit     = 1'b0;
        got_done     = 1'b0;
        start        = 1'b1;
        width        = WW'(m);
        poly         = p;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        while (n < 200 && !got_done) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("busy_after_start", 32'(busy), 32'd1);
                chk("in_ready_after_start", 32'(in_ready), 32'd1);
            end
            if (done) begin
                got_done  = 1'b1;
                lat       = n;
                start     = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                chk("busy_at_done", 32'(busy), 32'd0);
            end else begin
                if (spam && k < m) begin
                    start = 1'b1;
                    width = WW'(3);
                    poly  = 8'hFF;
                end else begin
                    start = 1'b0;
                end
                if (in_ready && out_valid)
                    chk("in_ready_and_out_valid", 32'(in_ready & out_valid), 32'd0);
                if (in_ready && k < m) begin
                    if (in_alt && tog) begin
                        in_valid = 1'b0;
                        in_a     = 1'($urandom_range(0, 1));
                        in_b     = 1'($urandom_range(0, 1));
                    end else begin
                        in_valid = 1'b1;
                        in_a     = a[m-1-k];
                        in_b     = b[m-1-k];
                        k++;
                    end
                    tog = !tog;
                end else begin
                    in_valid = 1'b0;
                end
                if (out_valid) begin
                    if (srem > 0) begin
                        out_ready = 1'b0;
                        chk("out_bit_hold", 32'(out_bit), 32'(held_bit));
                        srem--;
                    end else if (!stalled_once && ostall_len > 0 && j == ostall_at) begin
                        stalled_once = 1'b1;
                        srem         = ostall_len - 1;
                        held_bit     = out_bit;
                        out_ready    = 1'b0;
                    end else begin
                        if (stalled_once && j == ostall_at)
                            chk("out_bit_hold_release", 32'(out_bit), 32'(held_bit));
                        out_ready = 1'b1;
                        if (j < m) res[m-1-j] = out_bit;
                        j++;
                    end
                end else begin
                    out_ready = 1'b0;
                end
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
        $display("op m=%0d poly=%02h a=%02h b=%02h result=%02h latency=%0d", m, p, a, b, res, lat);
    endtask

    logic [7:0] res;
    int         lat;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        width     = '0;
        poly      = '0;
        in_valid  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_bit", 32'(out_bit), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // AES field product, no stalls
        @(negedge clk);
        do_op(8, 8'h1B, 8'h57, 8'h83, 1'b0, -1, 0, 1'b0, res, lat);
        chk("aes_result", 32'(res), 32'hC1);
        chk("aes_latency", 32'(lat), 32'd25);

        // m=4 with input stalls on alternating cycles: 3 stalls
        @(negedge clk);
        do_op(4, 8'h03, 8'h09, 8'h05, 1'b1, -1, 0, 1'b0, res, lat);
        chk("m4_stall_result", 32'(res), 32'hB);
        chk("m4_stall_latency", 32'(lat), 32'd16);

        // zero operand with a 3-cycle output stall mid-drain
        @(negedge clk);
        do_op(8, 8'h1B, 8'hFF, 8'h00, 1'b0, 3, 3, 1'b0, res, lat);
        chk("zero_result", 32'(res), 32'h00);
        chk("zero_ostall_latency", 32'(lat), 32'd28);

        // output stall on a nonzero result
        @(negedge clk);
        do_op(8, 8'h1B, 8'h57, 8'h83, 1'b0, 1, 3, 1'b0, res, lat);
        chk("aes_ostall_result", 32'(res), 32'hC1);
        chk("aes_ostall_latency", 32'(lat), 32'd28);

        // smallest degree
        @(negedge clk);
        do_op(1, 8'h01, 8'h01, 8'h01, 1'b0, -1, 0, 1'b0, res, lat);
        chk("m1_result", 32'(res), 32'h1);
        chk("m1_latency", 32'(lat), 32'd4);

        // illegal widths
        @(negedge clk);
        start = 1'b1;
        width = WW'(0);
        @(negedge clk);
        start = 1'b0;
        chk("err_w0_pulse", 32'(err), 32'd1);
        chk("err_w0_busy", 32'(busy), 32'd0);
        chk("err_w0_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("err_w0_clear", 32'(err), 32'd0);
        start = 1'b1;
        width = WW'(9);
        @(negedge clk);
        start = 1'b0;
        chk("err_w9_pulse", 32'(err), 32'd1);
        chk("err_w9_busy", 32'(busy), 32'd0);
        chk("err_w9_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("err_w9_clear", 32'(err), 32'd0);
        chk("err_w9_in_ready", 32'(in_ready), 32'd0);

        // reset asserted during MULT
        @(negedge clk);
        start = 1'b1;
        width = WW'(8);
        poly  = 8'h1B;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = 1'b1;
            in_b = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mult_busy", 32'(busy), 32'd1);
        chk("mult_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_outs", {27'd0, in_ready, out_valid, out_bit, done, err}, 32'd0);
        @(negedge clk);
        chk("rst_held_outs", {26'd0, busy, in_ready, out_valid, out_bit, done, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", {26'd0, busy, in_ready, out_valid, out_bit, done, err}, 32'd0);
        do_op(8, 8'h1B, 8'h02, 8'h80, 1'b0, -1, 0, 1'b0, res, lat);
        chk("post_rst_result", 32'(res), 32'h1B);
        chk("post_rst_latency", 32'(lat), 32'd25);

        // back-to-back: second start issued in the done cycle; start spam while busy
        @(negedge clk);
        do_op(8, 8'h1B, 8'h57, 8'h83, 1'b0, -1, 0, 1'b0, res, lat);
        chk("b2b_first_result", 32'(res), 32'hC1);
        do_op(4, 8'h03, 8'h09, 8'h05, 1'b0, -1, 0, 1'b1, res, lat);
        chk("b2b_second_result", 32'(res), 32'hB);
        chk("b2b_second_latency", 32'(lat), 32'd13);
        @(negedge clk);
        chk("idle_after_b2b", {29'd0, busy, done, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
